// File: rtl/mdio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdio_pkg : Clause 22 frame constants, FSM states and frame-builder helper |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
package mdio_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 16;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  localparam int PRE_LEN  = 32;
  localparam int HDR_LEN  = 14;
  localparam int DATA_LEN = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_HDR  = 3'd2,
    ST_TA   = 3'd3,
    ST_DATA = 3'd4,
    ST_DONE = 3'd5
  } mdio_state_e;

  // Everything after the preamble, MSB first; reads never drive the TA/DATA part.
  function automatic logic [31:0] mdio_frame(
    input logic [1:0]        op,
    input logic [ADDR_W-1:0] phy,
    input logic [ADDR_W-1:0] reg_a,
    input logic [DATA_W-1:0] data
  );
    return {MDIO_ST, op, phy, reg_a, MDIO_TA_WR, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdio_master_if : register-access request bus between sequencer and MDIO  |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
interface mdio_master_if;
  import mdio_pkg::*;

  logic              wren;
  logic              rden;
  logic [ADDR_W-1:0] phy_add;
  logic [ADDR_W-1:0] reg_add;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              ta_err;

  modport master (
    output wren, rden, phy_add, reg_add, wr_data,
    input  busy, rd_data, rd_valid, ta_err
  );

  modport slave (
    input  wren, rden, phy_add, reg_add, wr_data,
    output busy, rd_data, rd_valid, ta_err
  );
endinterface
`default_nettype wire

// File: rtl/mdio_clk_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdio_clk_gen : MDC divider, low half first, with bit-boundary strobes    |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module mdio_clk_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mdc,
  output logic fall_stb,
  output logic samp_stb
);

  localparam int            CNT_W    = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mdc_q, mdc_d;

  // Position within the bit period; held at zero while idle so the first bit
  // after a capture starts its low half on the capture edge.
  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != C_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
    mdc_d = (cnt_d >= C_HALF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

  assign mdc      = mdc_q;
  assign fall_stb = en & (cnt_q == C_LAST);
  assign samp_stb = en & (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mdio_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdio_master : Clause 22 MDIO master turning single-cycle requests into   |
// |               serial MDC/MDIO read and write frames. Revision : 1.0      |
// +--------------------------------------------------------------------------+
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV     = 10,
  parameter bit PREAMBLE_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  mdio_master_if.slave bus,
  output logic         mdc,
  output logic         mdio_o,
  output logic         mdio_oe,
  input  logic         mdio_i
);

  mdio_state_e       state_q, state_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [31:0]       tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              is_rd_q, is_rd_d;
  logic              ta_bad_q, ta_bad_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ta_err_q, ta_err_d;
  logic              mdio_o_q, mdio_o_d;
  logic              mdio_oe_q, mdio_oe_d;
  logic              sync1_q, sync2_q;

  logic              fall_stb;
  logic              samp_stb;
  logic              capture;
  logic              bit_start;

  mdio_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (busy_q),
    .mdc      (mdc),
    .fall_stb (fall_stb),
    .samp_stb (samp_stb)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    is_rd_d    = is_rd_q;
    ta_bad_d   = ta_bad_q;
    busy_d     = busy_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ta_err_d   = ta_err_q;
    mdio_o_d   = mdio_o_q;
    mdio_oe_d  = mdio_oe_q;
    capture    = (bus.wren | bus.rden) & ~busy_q;
    bit_start  = 1'b0;

    if (samp_stb && is_rd_q) begin
      if ((state_q == ST_TA) && (bit_cnt_q == '0)) begin
        ta_bad_d = sync2_q;
      end
      if (state_q == ST_DATA) begin
        rx_d = {rx_q[DATA_W-2:0], sync2_q};
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          bit_start = 1'b1;
          busy_d    = 1'b1;
          is_rd_d   = ~bus.wren;
          ta_bad_d  = 1'b0;
          tx_d      = mdio_frame(bus.wren ? MDIO_OP_WR : MDIO_OP_RD,
                                 bus.phy_add, bus.reg_add, bus.wr_data);
          if (PREAMBLE_EN) begin
            state_d   = ST_PRE;
            bit_cnt_d = 6'(PRE_LEN - 1);
          end else begin
            state_d   = ST_HDR;
            bit_cnt_d = 6'(HDR_LEN - 1);
          end
        end
      end
      default: begin
        if (fall_stb) begin
          bit_start = 1'b1;
          if (bit_cnt_q != '0) begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end else begin
            case (state_q)
              ST_PRE: begin
                state_d   = ST_HDR;
                bit_cnt_d = 6'(HDR_LEN - 1);
              end
              ST_HDR: begin
                state_d   = ST_TA;
                bit_cnt_d = 6'd1;
              end
              ST_TA: begin
                state_d   = ST_DATA;
                bit_cnt_d = 6'(DATA_LEN - 1);
              end
              ST_DATA: begin
                state_d   = ST_DONE;
                bit_cnt_d = 6'd0;
              end
              default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (is_rd_q) begin
                  rd_data_d  = rx_q;
                  ta_err_d   = ta_bad_q;
                  rd_valid_d = 1'b1;
                end
              end
            endcase
          end
        end
      end
    endcase

    // Pin values for the bit that begins on this edge; the bus is released
    // during the trailing DONE period and while idle.
    if (bit_start) begin
      mdio_oe_d = 1'b1;
      mdio_o_d  = 1'b1;
      case (state_d)
        ST_PRE: begin
        end
        ST_HDR: begin
          mdio_o_d = tx_d[31];
          tx_d     = {tx_d[30:0], 1'b0};
        end
        ST_TA, ST_DATA: begin
          if (is_rd_d) begin
            mdio_oe_d = 1'b0;
          end else begin
            mdio_o_d = tx_d[31];
            tx_d     = {tx_d[30:0], 1'b0};
          end
        end
        default: begin
          mdio_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      is_rd_q    <= 1'b0;
      ta_bad_q   <= 1'b0;
      busy_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ta_err_q   <= 1'b0;
      mdio_o_q   <= 1'b1;
      mdio_oe_q  <= 1'b0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      is_rd_q    <= is_rd_d;
      ta_bad_q   <= ta_bad_d;
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ta_err_q   <= ta_err_d;
      mdio_o_q   <= mdio_o_d;
      mdio_oe_q  <= mdio_oe_d;
      sync1_q    <= mdio_i;
      sync2_q    <= sync1_q;
    end
  end

  assign mdio_o       = mdio_o_q;
  assign mdio_oe      = mdio_oe_q;
  assign bus.busy     = busy_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.ta_err   = ta_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mdio_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mdio_master : directed + randomized bench with a frame-level PHY model |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_mdio_master;

  localparam int DIV0 = 4;   // instance with preamble
  localparam int DIV1 = 5;   // instance without preamble

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        wren_v = 1'b0;
  logic        rden_v = 1'b0;
  logic [4:0]  phy_v = '0;
  logic [4:0]  reg_v = '0;
  logic [15:0] wd_v = '0;
  logic        mdio_i = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdio_master_if bus0();
  mdio_master_if bus1();

  assign bus0.wren    = wren_v & ~sel;
  assign bus0.rden    = rden_v & ~sel;
  assign bus1.wren    = wren_v & sel;
  assign bus1.rden    = rden_v & sel;
  assign bus0.phy_add = phy_v;
  assign bus1.phy_add = phy_v;
  assign bus0.reg_add = reg_v;
  assign bus1.reg_add = reg_v;
  assign bus0.wr_data = wd_v;
  assign bus1.wr_data = wd_v;

  wire mdc0, mdo0, mdoe0, mdc1, mdo1, mdoe1;

  mdio_master #(.CLK_DIV(DIV0), .PREAMBLE_EN(1'b1)) u_dut_pre (
    .clk(clk), .rst(rst), .bus(bus0),
    .mdc(mdc0), .mdio_o(mdo0), .mdio_oe(mdoe0), .mdio_i(mdio_i)
  );

  mdio_master #(.CLK_DIV(DIV1), .PREAMBLE_EN(1'b0)) u_dut_np (
    .clk(clk), .rst(rst), .bus(bus1),
    .mdc(mdc1), .mdio_o(mdo1), .mdio_oe(mdoe1), .mdio_i(mdio_i)
  );

  wire        mdc_m  = sel ? mdc1  : mdc0;
  wire        mdo_m  = sel ? mdo1  : mdo0;
  wire        mdoe_m = sel ? mdoe1 : mdoe0;
  wire        busy_m = sel ? bus1.busy     : bus0.busy;
  wire        rv_m   = sel ? bus1.rd_valid : bus0.rd_valid;
  wire        err_m  = sel ? bus1.ta_err   : bus0.ta_err;
  wire [15:0] rd_m   = sel ? bus1.rd_data  : bus0.rd_data;

  // Line recorder and PHY model, both keyed on MDC rising edges.
  int edge_cnt = 0;
  int frame_base = 0;
  int rv_cnt = 0;
  bit obs_o  [4096];
  bit obs_oe [4096];
  bit phy_resp [64];

  always @(posedge mdc_m) begin
    obs_o[edge_cnt % 4096]  <= mdo_m;
    obs_oe[edge_cnt % 4096] <= mdoe_m;
    edge_cnt <= edge_cnt + 1;
    if ((edge_cnt - frame_base) >= 0 && (edge_cnt - frame_base) < 64)
      mdio_i <= phy_resp[edge_cnt - frame_base];
    else
      mdio_i <= 1'b1;
  end

  always @(posedge clk) begin
    if (rv_m) rv_cnt <= rv_cnt + 1;
  end

  // Expected line contents of one frame, built from the Clause 22 field layout.
  bit exp_o  [72];
  bit exp_oe [72];
  int n_exp;
  logic [15:0] exp_rd  [2];
  logic        exp_err [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input bit pre, input bit wr, input logic [4:0] pa,
                           input logic [4:0] ra, input logic [15:0] d);
    int i;
    logic [13:0] hdr;
    i = 0;
    if (pre) begin
      for (int b = 0; b < 32; b++) begin exp_o[i] = 1'b1; exp_oe[i] = 1'b1; i++; end
    end
    hdr = {2'b01, (wr ? 2'b01 : 2'b10), pa, ra};
    for (int b = 13; b >= 0; b--) begin exp_o[i] = hdr[b]; exp_oe[i] = 1'b1; i++; end
    exp_o[i] = 1'b1; exp_oe[i] = wr; i++;
    exp_o[i] = 1'b0; exp_oe[i] = wr; i++;
    for (int b = 15; b >= 0; b--) begin
      exp_o[i] = wr ? d[b] : 1'b0; exp_oe[i] = wr; i++;
    end
    n_exp = i + 1;  // plus the trailing idle bit period
  endtask

  // mode: 0 = PHY answers TA=0 and data, 1 = TA left high but data answered,
  //       2 = PHY silent (line pulled high throughout)
  task automatic run_frame(input bit s, input bit wr, input bit rd,
                           input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input int mode,
                           input logic [15:0] rdv, input bit mid_pulse);
    bit is_rd;
    int div, hs, cycles, rv0, mism, first, idx;
    is_rd = !wr && rd;
    div   = s ? DIV1 : DIV0;
    hs    = s ? 0 : 32;
    sel   = s;
    build_exp(!s, !is_rd, pa, ra, wd);
    for (int i = 0; i < 64; i++) phy_resp[i] = 1'b1;
    if (is_rd && mode != 2) begin
      if (mode == 0) begin phy_resp[hs+14] = 1'b0; phy_resp[hs+15] = 1'b0; end
      for (int b = 0; b < 16; b++) phy_resp[hs+16+b] = rdv[15-b];
    end
    if (is_rd) begin
      exp_rd[s]  = (mode == 2) ? 16'hFFFF : rdv;
      exp_err[s] = (mode != 0);
    end
    rv0 = rv_cnt;
    @(negedge clk);
    frame_base = edge_cnt;
    wren_v = wr; rden_v = rd; phy_v = pa; reg_v = ra; wd_v = wd;
    @(posedge clk); #1;
    chk("capture_busy", {31'd0, busy_m}, 32'd1);
    wren_v = 1'b0; rden_v = 1'b0;
    cycles = 0;
    while (busy_m && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
      if (mid_pulse) begin
        if (cycles == 100) begin wren_v = 1'b1; wd_v = ~wd; end
        else wren_v = 1'b0;
      end
    end
    wren_v = 1'b0;
    chk("busy_width", cycles, n_exp * 2 * div);
    chk("rd_valid_at_fall", {31'd0, rv_m}, {31'd0, is_rd});
    chk("rd_data", {16'd0, rd_m}, {16'd0, exp_rd[s]});
    chk("ta_err", {31'd0, err_m}, {31'd0, exp_err[s]});
    repeat (3) @(posedge clk);
    #1;
    chk("rd_valid_pulses", rv_cnt - rv0, {31'd0, is_rd});
    chk("mdc_edges", edge_cnt - frame_base, n_exp);
    mism = 0; first = -1;
    for (int i = 0; i < n_exp - 1; i++) begin
      idx = (frame_base + i) % 4096;
      if (obs_oe[idx] !== exp_oe[i] || (exp_oe[i] && obs_o[idx] !== exp_o[i])) begin
        mism++;
        if (first < 0) first = i;
      end
    end
    chk($sformatf("frame_bits(first_bad_bit=%0d)", first), mism, 0);
    chk("idle_pins_mdc_oe_o_busy", {28'd0, mdc_m, mdoe_m, mdo_m, busy_m}, 32'h2);
  endtask

  initial begin
    int cyc;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    for (int i = 0; i < 64; i++) phy_resp[i] = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_pins", {29'd0, mdc0, mdoe0, mdo0}, 32'h1);
    chk("reset_status", {12'd0, bus0.busy, bus0.rd_valid, bus0.ta_err, bus0.rd_data},
        32'h0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);

    // Directed frames
    run_frame(1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 16'h1100, 0, 16'h0000, 1'b0);
    run_frame(1'b0, 1'b0, 1'b1, 5'd2, 5'd1, 16'h0000, 0, 16'hABCD, 1'b0);
    run_frame(1'b0, 1'b0, 1'b1, 5'd3, 5'd2, 16'h0000, 2, 16'h0000, 1'b0);
    run_frame(1'b0, 1'b1, 1'b0, 5'd4, 5'd9, 16'h5A5A, 0, 16'h0000, 1'b0);
    run_frame(1'b1, 1'b1, 1'b1, 5'd7, 5'd3, 16'hC3E1, 0, 16'h0000, 1'b1);

    // Reset in the middle of a write, at bit 40
    sel = 1'b0;
    @(negedge clk);
    frame_base = edge_cnt;
    wren_v = 1'b1; phy_v = 5'd5; reg_v = 5'd6; wd_v = 16'hBEEF;
    @(posedge clk); #1;
    wren_v = 1'b0;
    cyc = 0;
    while ((edge_cnt - frame_base) <= 40 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reached_bit40", {31'd0, (edge_cnt - frame_base) > 40}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_pins", {29'd0, mdc0, mdoe0, mdo0}, 32'h1);
    chk("midrst_status", {12'd0, bus0.busy, bus0.rd_valid, bus0.ta_err, bus0.rd_data},
        32'h0);
    exp_rd[0] = '0; exp_rd[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    run_frame(1'b0, 1'b1, 1'b0, 5'd5, 5'd6, 16'hBEEF, 0, 16'h0000, 1'b0);

    // Randomized frames on both instances
    for (int k = 0; k < 12; k++) begin
      bit s, w, r;
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      run_frame(s, w, r, 5'($urandom), 5'($urandom), 16'($urandom),
                int'($urandom_range(0, 2)), 16'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mdio_master.md
# mdio_master

Clause 22 MDIO management master that turns single-cycle register access requests into serial MDC/MDIO frames toward the ADIN1300 PHYs. It sits directly downstream of the PHY configuration sequencer. It consumes that sequencer's `wren`, `phy_add`, `reg_add` and `wr_data` and returns `busy`. Read support returns PHY register contents and a turnaround error flag for status polling.

## Interface
- `CLK_DIV`, 10: clk cycles per MDC half-period; legal range 4..255; MDC = f_clk / (2·CLK_DIV).
- `PREAMBLE_EN`, 1: 1 sends a 32-bit all-ones preamble; 0 suppresses it.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; asynchronous, active-high.
- `wren`  in  1  write request; sampled on rising `clk`.
- `rden`  in  1  read request; sampled on rising `clk`.
- `phy_add`  in  5  target PHY address.
- `reg_add`  in  5  target register address.
- `wr_data`  in  16  write payload.
- `busy`  out  1  frame in progress; new requests are ignored while high.
- `rd_data`  out  16  last read result; held until the next read completes.
- `rd_valid`  out  1  one-cycle pulse when `rd_data` updates.
- `ta_err`  out  1  the last read had a turnaround error; held until the next read completes.
- `mdc`  out  1  management clock.
- `mdio_o`  out  1  MDIO drive value.
- `mdio_oe`  out  1  MDIO output enable; drives the external tristate.
- `mdio_i`  in  1  MDIO pin input; asynchronous.

## Operation
- Request capture happens on rising `clk` when (`wren` | `rden`) & !`busy`.
  - `phy_add`, `reg_add`, `wr_data` and the opcode are latched on the same edge.
  - `wren` wins when both requests are high; that `rden` is dropped.
  - Requests seen while `busy`=1 are dropped. They are not queued.
- Frame bits, MSB first:
  - PRE: 32×'1', or omitted when `PREAMBLE_EN`=0.
  - ST = 01.
  - OP = 01 (write) or 10 (read).
  - PHYAD[4:0], then REGAD[4:0].
  - TA, then DATA[15:0].
- Write frame:
  - TA = "10", driven by the master.
  - DATA = latched `wr_data`.
  - `mdio_oe`=1 for the whole frame.
- Read frame:
  - `mdio_oe`=1 through REGAD.
  - `mdio_oe`=0 from the first TA bit to the end of the frame.
  - The second TA bit is sampled; if it is not 0, `ta_err`=1 for this read.
  - DATA is shifted in from sampled `mdio_i`.
- State machine:
  - IDLE → PRE (or HDR when `PREAMBLE_EN`=0) on capture.
  - PRE → HDR after 32 bits.
  - HDR (ST+OP+PHYAD+REGAD) → TA after 14 bits.
  - TA → DATA after 2 bits.
  - DATA → DONE after 16 bits.
  - DONE → IDLE after 1 bit period.
- A 6-bit bit counter is reloaded on each state entry.
- `mdio_i` passes through a 2-flop synchronizer before use.

## Timing
- Bit period is 2·CLK_DIV clk cycles:
  - low half first, `mdc`=0;
  - then high half, `mdc`=1.
- `mdio_o` and `mdio_oe` change only on the clk edge that starts a low half. This is the MDC falling edge, or the first bit after capture.
- Input sampling uses synchronized `mdio_i` on the last clk cycle of each high half. This leaves CLK_DIV−2 cycles of margin after the MDC rising edge.
- In IDLE: `mdc`=0, `mdio_oe`=0, `mdio_o`=1.
- `busy` rises on the capture edge.
- `busy` falls exactly N·2·CLK_DIV cycles after capture:
  - N = 65 with preamble (32+14+2+16+1);
  - N = 33 without.
- A new request can be captured on the edge after `busy` falls.
- On a read, `rd_data`, `ta_err` and the `rd_valid` pulse all update on the edge where `busy` falls.
- Writes leave `rd_data` and `ta_err` unchanged and raise no `rd_valid`.
- Reset values, applied immediately and asynchronously, also when `rst` is asserted mid-frame:
  - `mdc`=0, `mdio_o`=1, `mdio_oe`=0;
  - `busy`=0, `rd_valid`=0;
  - `rd_data`=0, `ta_err`=0;
  - state IDLE, divider and bit counter cleared.
- A partial frame is abandoned on reset; the PHY resynchronizes on the next preamble.

## Structure
- Package `mdio_pkg` holds:
  - the state enum;
  - `MDIO_ST`=2'b01, `MDIO_OP_WR`=2'b01, `MDIO_OP_RD`=2'b10, `MDIO_TA_WR`=2'b10;
  - `PRE_LEN`=32, `HDR_LEN`=14, `DATA_LEN`=16.
- Sub-module `mdio_clk_gen(CLK_DIV)` contains:
  - inputs `en` and `rst`;
  - outputs `mdc`, `fall_stb` (start of low half) and `samp_stb` (last cycle of high half);
  - a counter that is held cleared while `en`=0.
- Top level holds the FSM, bit counter, TX shift register (32 bits, loaded at capture), RX shift register and synchronizer.

## Test plan
- Write, PHY 1, reg 0x00, data 0x1100, CLK_DIV=4, preamble on:
  - decoded MDIO at MDC rising edges = 32×'1', 01 01 00001 00000 10 0001000100000000;
  - `busy` high for exactly 520 clk cycles.
- Read, PHY 2, reg 0x01; bench PHY model drives TA0=0 and data 0xABCD:
  - `rd_data`=0xABCD, `rd_valid` pulses once, `ta_err`=0;
  - `mdio_oe`=0 from TA start to frame end.
- Read where the model leaves MDIO pulled high during TA:
  - `ta_err`=1;
  - `rd_data`=0xFFFF.
- `wren` and `rden` high on the same capture edge, PREAMBLE_EN=0:
  - write frame (OP=01) sent;
  - `busy` width = 33·2·CLK_DIV;
  - second `wren` pulse issued mid-frame is ignored, with no second frame.
- `rst` asserted at bit 40 of a write:
  - all outputs at reset values within the same cycle;
  - the next request after release produces a complete, correct frame.
